// File: rtl/kuznechik_pkg.sv
// Shared Kuznechik constants, key-store state encoding and GOST R 34.12-2015
// reference round keys (used by benches).
package kuznechik_pkg;

  localparam int KEY_W          = 128;
  localparam int NUM_ROUND_KEYS = 10;
  localparam int IDX_W          = 4;

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_LOADED = 2'd1,
    ST_REPLAY = 2'd2,
    ST_SCRUB  = 2'd3
  } ks_state_e;

  localparam logic [KEY_W-1:0] GOST_RK [NUM_ROUND_KEYS] = '{
    128'h8899aabbccddeeff0011223344556677,
    128'hfedcba98765432100123456789abcdef,
    128'hdb31485315694343228d6aef8cc78c44,
    128'h3d4553d8e9cfec6815ebadc40a9ffd04,
    128'h57646468c44a5e28d3e59246f429f1ac,
    128'hbd079435165c6432b532e82834da581b,
    128'h51e640757e8745de705727265a0098b1,
    128'h5a7925017b9fdd3ed72a91a22286f984,
    128'hbb44e25378c73123a5f32f73cdb6e517,
    128'h72e9dd7416bcf45b755dbaa88e4a4043
  };

  // Pair i as the generator emits it: {K(2i+1), K(2i+2)}.
  function automatic logic [2*KEY_W-1:0] gost_pair(input int i);
    return {GOST_RK[2*i], GOST_RK[2*i+1]};
  endfunction

endpackage

// File: rtl/kuznechik_key_ram.sv
// NUM_KEYS x KEY_W round-key register file: one pair write port (slots
// wr_slot and wr_slot+1), one single-slot clear port, one async read port.
module kuznechik_key_ram
  import kuznechik_pkg::*;
#(
  parameter int NUM_KEYS = NUM_ROUND_KEYS,
  parameter int KEY_W    = kuznechik_pkg::KEY_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [IDX_W-1:0]     wr_slot,
  input  logic [2*KEY_W-1:0]   wr_pair,
  input  logic                 clr_en,
  input  logic [IDX_W-1:0]     clr_slot,
  input  logic [IDX_W-1:0]     rd_slot,
  output logic [KEY_W-1:0]     rd_data
);

  logic [KEY_W-1:0] mem_q [NUM_KEYS];
  logic [IDX_W-1:0] wr_slot_lo;

  assign wr_slot_lo = wr_slot + IDX_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_KEYS; i++) mem_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        if (clr_en && clr_slot == IDX_W'(i)) begin
          mem_q[i] <= '0;
        end else if (wr_en && wr_slot == IDX_W'(i)) begin
          mem_q[i] <= wr_pair[2*KEY_W-1:KEY_W];
        end else if (wr_en && wr_slot_lo == IDX_W'(i)) begin
          mem_q[i] <= wr_pair[KEY_W-1:0];
        end
      end
    end
  end

  assign rd_data = (int'(rd_slot) < NUM_KEYS) ? mem_q[rd_slot] : '0;

endmodule

// File: rtl/kuznechik_key_store.sv
// Round-key store between keygen and encrypt: captures key pairs, replays
// K1..K10 with keyset/key_valid framing. Option: KUZNECHIK_KEY_STORE_SCRUB_EN.
//
// state     | meaning
// ----------+----------------------------------------------------------
// ST_FILL   | collecting pairs from the generator, cipher held in keyset
// ST_LOADED | all keys present, idle, waiting for replay
// ST_REPLAY | streaming K1..K(NUM_KEYS), one key per cycle
// ST_SCRUB  | zeroing one slot per cycle after clear/reset (option only)
module kuznechik_key_store
  import kuznechik_pkg::*;
#(
  parameter int NUM_KEYS = NUM_ROUND_KEYS,  // even, 2..16
  parameter int KEY_W    = kuznechik_pkg::KEY_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 pair_valid,
  input  logic [2*KEY_W-1:0]   pair_data,
  input  logic                 gen_done,
  input  logic                 replay,
  output logic [KEY_W-1:0]     key_out,
  output logic                 key_valid,
  output logic                 keyset,
  output logic                 keys_loaded,
  output logic [IDX_W-1:0]     key_idx,
  output logic                 err,
  output logic                 busy
);

  localparam logic [IDX_W:0]   WP_FULL   = (IDX_W+1)'(NUM_KEYS);
  localparam logic [IDX_W:0]   WP_LAST   = (IDX_W+1)'(NUM_KEYS - 2);
  localparam logic [IDX_W-1:0] CNT_LAST  = IDX_W'(NUM_KEYS - 1);
`ifdef KUZNECHIK_KEY_STORE_SCRUB_EN
  localparam ks_state_e        ST_RESTART = ST_SCRUB;
`else
  localparam ks_state_e        ST_RESTART = ST_FILL;
`endif

  ks_state_e          state_q, state_d;
  logic [IDX_W:0]     wp_q, wp_d;
  logic [IDX_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;
  logic [KEY_W-1:0]   key_out_q, key_out_d;
  logic               key_valid_q, key_valid_d;
  logic [IDX_W-1:0]   key_idx_q, key_idx_d;
  logic               keyset_q, keyset_d;
  logic               keys_loaded_q, keys_loaded_d;

  logic               ram_wr_en, ram_clr_en;
  logic [IDX_W-1:0]   ram_rd_slot;
  logic [KEY_W-1:0]   ram_rd_data;

  kuznechik_key_ram #(
    .NUM_KEYS (NUM_KEYS),
    .KEY_W    (KEY_W)
  ) u_ram (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (ram_wr_en),
    .wr_slot  (wp_q[IDX_W-1:0]),
    .wr_pair  (pair_data),
    .clr_en   (ram_clr_en),
    .clr_slot (cnt_q),
    .rd_slot  (ram_rd_slot),
    .rd_data  (ram_rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_RESTART;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ST_RESTART;
    end else begin
      case (state_q)
        ST_FILL:   if (pair_valid && wp_q == WP_LAST) state_d = ST_LOADED;
        ST_LOADED: if (replay)                        state_d = ST_REPLAY;
        ST_REPLAY: if (cnt_q == CNT_LAST)             state_d = ST_LOADED;
        ST_SCRUB:  if (cnt_q == CNT_LAST)             state_d = ST_FILL;
        default:                                      state_d = ST_RESTART;
      endcase
    end
  end

  always_comb begin
    ram_wr_en     = 1'b0;
    ram_clr_en    = 1'b0;
    ram_rd_slot   = '0;
    wp_d          = wp_q;
    cnt_d         = cnt_q;
    err_d         = err_q;
    key_out_d     = '0;
    key_valid_d   = 1'b0;
    key_idx_d     = '0;
    keyset_d      = (state_d != ST_LOADED);
    keys_loaded_d = (state_d == ST_LOADED) || (state_d == ST_REPLAY);
    if (clear) begin
      wp_d  = '0;
      cnt_d = '0;
      err_d = 1'b0;
    end else begin
      case (state_q)
        ST_FILL: begin
          if (pair_valid) begin
            ram_wr_en = 1'b1;
            wp_d      = wp_q + (IDX_W+1)'(2);
          end
          // a done pulse alongside the final pair counts as complete
          if (gen_done && wp_d != WP_FULL) err_d = 1'b1;
        end
        ST_LOADED: begin
          if (pair_valid) err_d = 1'b1;
          if (replay) begin
            key_valid_d = 1'b1;
            key_out_d   = ram_rd_data;
            cnt_d       = '0;
          end
        end
        ST_REPLAY: begin
          if (pair_valid) err_d = 1'b1;
          if (cnt_q != CNT_LAST) begin
            ram_rd_slot = cnt_q + IDX_W'(1);
            key_valid_d = 1'b1;
            key_out_d   = ram_rd_data;
            key_idx_d   = ram_rd_slot;
            cnt_d       = ram_rd_slot;
          end
        end
        ST_SCRUB: begin
          if (pair_valid) err_d = 1'b1;
          ram_clr_en = 1'b1;
          cnt_d      = (cnt_q == CNT_LAST) ? '0 : cnt_q + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q          <= '0;
      cnt_q         <= '0;
      err_q         <= 1'b0;
      key_out_q     <= '0;
      key_valid_q   <= 1'b0;
      key_idx_q     <= '0;
      keyset_q      <= 1'b0;
      keys_loaded_q <= 1'b0;
    end else begin
      wp_q          <= wp_d;
      cnt_q         <= cnt_d;
      err_q         <= err_d;
      key_out_q     <= key_out_d;
      key_valid_q   <= key_valid_d;
      key_idx_q     <= key_idx_d;
      keyset_q      <= keyset_d;
      keys_loaded_q <= keys_loaded_d;
    end
  end

`ifdef KUZNECHIK_KEY_STORE_SCRUB_EN
  logic busy_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= 1'b0;
    else        busy_q <= (state_d == ST_SCRUB);
  end
  assign busy = busy_q;
`else
  assign busy = 1'b0;
`endif

  assign key_out     = key_out_q;
  assign key_valid   = key_valid_q;
  assign key_idx     = key_idx_q;
  assign keyset      = keyset_q;
  assign keys_loaded = keys_loaded_q;
  assign err         = err_q;

endmodule

// File: tb/tb_kuznechik_key_store.sv
// Self-checking bench for kuznechik_key_store: vector table for fill/first
// replay, scoreboard queue for streamed keys, sequences for corner cases.
`timescale 1ns/1ps
module tb_kuznechik_key_store;
  import kuznechik_pkg::*;

  localparam int NK = NUM_ROUND_KEYS;

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic               clear = 1'b0;
  logic               pair_valid = 1'b0;
  logic [2*KEY_W-1:0] pair_data = '0;
  logic               gen_done = 1'b0;
  logic               replay = 1'b0;
  logic [KEY_W-1:0]   key_out;
  logic               key_valid, keyset, keys_loaded, err, busy;
  logic [3:0]         key_idx;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  kuznechik_key_store dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (clear),
    .pair_valid  (pair_valid),
    .pair_data   (pair_data),
    .gen_done    (gen_done),
    .replay      (replay),
    .key_out     (key_out),
    .key_valid   (key_valid),
    .keyset      (keyset),
    .keys_loaded (keys_loaded),
    .key_idx     (key_idx),
    .err         (err),
    .busy        (busy)
  );

  typedef struct {
    logic [3:0]       idx;
    logic [KEY_W-1:0] key;
  } sb_t;

  typedef struct {
    logic               pv, gd, rp;
    logic [2*KEY_W-1:0] pd;
    logic               e_loaded, e_err, e_keyset, e_kv;
  } vec_t;

  sb_t              exp_q[$];
  sb_t              mon_e;
  logic [KEY_W-1:0] model [NK];
  vec_t             tbl [NK/2 + 1];

  task automatic chk_b(input string name, input logic got, input logic exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, got, exp);
  endtask

  task automatic chk_i(input string name, input logic [3:0] got, input logic [3:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  task automatic chk_w(input string name, input logic [KEY_W-1:0] got, input logic [KEY_W-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_keys(input int n);
    for (int k = 0; k < n; k++) exp_q.push_back('{idx: 4'(k), key: model[k]});
  endtask

  // Remaining key_valid cycles of a stream, then the closing cycle.
  task automatic stream_tail(input string tag, input int n_more);
    for (int k = 0; k < n_more; k++) begin
      step();
      chk_b({tag, "_kv_run"}, key_valid, 1'b1);
    end
    step();
    chk_b({tag, "_end_kv"}, key_valid, 1'b0);
    chk_b({tag, "_end_keyset"}, keyset, 1'b0);
    chk_w({tag, "_end_key"}, key_out, '0);
    chk_b({tag, "_end_loaded"}, keys_loaded, 1'b1);
    chk_b({tag, "_sb_empty"}, exp_q.size() == 0, 1'b1);
  endtask

  task automatic wait_scrub(input string tag);
`ifdef KUZNECHIK_KEY_STORE_SCRUB_EN
    int n = 0;
    while (busy && n < 4*NK) begin
      step();
      n++;
    end
    chk_b({tag, "_scrub_done"}, busy, 1'b0);
`else
    chk_b({tag, "_busy_tied0"}, busy, 1'b0);
`endif
  endtask

  task automatic do_clear(input string tag);
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk_b({tag, "_clr_err"}, err, 1'b0);
    chk_b({tag, "_clr_loaded"}, keys_loaded, 1'b0);
    wait_scrub(tag);
  endtask

  function automatic logic [KEY_W-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Stream monitor: every key_valid cycle must match the next queued key.
  always @(negedge clk) begin
    if (rst_n) begin
      if (key_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL stream_extra: key_valid=1 idx=%0d key=%h, expected no key", key_idx, key_out);
        end else begin
          mon_e = exp_q.pop_front();
          chk_i("stream_idx", key_idx, mon_e.idx);
          chk_w("stream_key", key_out, mon_e.key);
        end
      end else begin
        chk_w("key_out_zero_idle", key_out, '0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout required $finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < NK; i++) model[i] = GOST_RK[i];
    for (int i = 0; i < NK/2; i++)
      tbl[i] = '{pv: 1'b1, gd: (i == NK/2-1), rp: 1'b0, pd: gost_pair(i),
                 e_loaded: (i == NK/2-1), e_err: 1'b0, e_keyset: (i != NK/2-1), e_kv: 1'b0};
    tbl[NK/2] = '{pv: 1'b0, gd: 1'b0, rp: 1'b1, pd: '0,
                  e_loaded: 1'b1, e_err: 1'b0, e_keyset: 1'b1, e_kv: 1'b1};

    // reset
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_b("rst_kv", key_valid, 1'b0);
    chk_b("rst_keyset", keyset, 1'b0);
    chk_b("rst_loaded", keys_loaded, 1'b0);
    chk_b("rst_err", err, 1'b0);
    chk_b("rst_busy", busy, 1'b0);
    chk_i("rst_idx", key_idx, 4'd0);
    chk_w("rst_key", key_out, '0);
    rst_n = 1'b1;
    step();
    chk_b("post_rst_keyset", keyset, 1'b1);
    wait_scrub("post_rst");

    // GOST fill + first replay from the vector table
    for (int i = 0; i <= NK/2; i++) begin
      pair_valid = tbl[i].pv;
      pair_data  = tbl[i].pd;
      gen_done   = tbl[i].gd;
      replay     = tbl[i].rp;
      if (tbl[i].rp) push_keys(NK);
      step();
      chk_b($sformatf("v%0d_loaded", i), keys_loaded, tbl[i].e_loaded);
      chk_b($sformatf("v%0d_err", i), err, tbl[i].e_err);
      chk_b($sformatf("v%0d_keyset", i), keyset, tbl[i].e_keyset);
      chk_b($sformatf("v%0d_kv", i), key_valid, tbl[i].e_kv);
    end
    pair_valid = 1'b0;
    gen_done   = 1'b0;
    replay     = 1'b0;
    stream_tail("gost", NK-1);
    chk_b("gost_err_after", err, 1'b0);

    // extra pair in LOADED, replay re-pulsed mid-stream
    pair_valid = 1'b1;
    pair_data  = {rnd128(), rnd128()};
    step();
    pair_valid = 1'b0;
    chk_b("extra_pair_err", err, 1'b1);
    chk_b("extra_pair_loaded", keys_loaded, 1'b1);
    chk_b("extra_pair_keyset", keyset, 1'b0);
    replay = 1'b1;
    push_keys(NK);
    step();
    replay = 1'b0;
    step();
    step();
    replay = 1'b1;
    step();
    replay = 1'b0;
    stream_tail("repulse", NK-4);
    chk_b("repulse_err_sticky", err, 1'b1);

    // clear at stream cycle 4
    replay = 1'b1;
    push_keys(5);
    step();
    replay = 1'b0;
    repeat (4) step();
    chk_i("cut_idx4", key_idx, 4'd4);
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk_b("cut_kv", key_valid, 1'b0);
    chk_b("cut_loaded", keys_loaded, 1'b0);
    chk_b("cut_err", err, 1'b0);
    chk_b("cut_keyset", keyset, 1'b1);
    chk_b("cut_sb_empty", exp_q.size() == 0, 1'b1);
`ifdef KUZNECHIK_KEY_STORE_SCRUB_EN
    chk_b("scrub_busy_c1", busy, 1'b1);
    pair_valid = 1'b1;
    pair_data  = {rnd128(), rnd128()};
    step();
    pair_valid = 1'b0;
    chk_b("scrub_busy_c2", busy, 1'b1);
    chk_b("scrub_pair_err", err, 1'b1);
    for (int k = 3; k <= NK; k++) begin
      step();
      chk_b($sformatf("scrub_busy_c%0d", k), busy, 1'b1);
    end
    step();
    chk_b("scrub_busy_end", busy, 1'b0);
    chk_b("scrub_keyset", keyset, 1'b1);
    for (int k = 0; k < NK; k++)
      chk_w($sformatf("scrub_mem%0d", k), dut.u_ram.mem_q[k], '0);
    do_clear("post_scrub");
`else
    chk_b("cut_busy0", busy, 1'b0);
`endif

    // short fill: replay in FILL ignored, early gen_done flags error
    for (int p = 0; p < 3; p++) begin
      pair_valid = 1'b1;
      pair_data  = {rnd128(), rnd128()};
      step();
      chk_b($sformatf("short_p%0d_err", p), err, 1'b0);
    end
    pair_valid = 1'b0;
    replay = 1'b1;
    step();
    replay = 1'b0;
    chk_b("fill_replay_kv", key_valid, 1'b0);
    chk_b("fill_replay_err", err, 1'b0);
    gen_done = 1'b1;
    step();
    gen_done = 1'b0;
    chk_b("short_done_err", err, 1'b1);
    chk_b("short_done_loaded", keys_loaded, 1'b0);
    chk_b("short_done_keyset", keyset, 1'b1);
    repeat (3) step();
    chk_b("short_err_sticky", err, 1'b1);
    chk_b("short_loaded_still0", keys_loaded, 1'b0);
    do_clear("short");

    // refill with fresh keys and replay
    for (int p = 0; p < NK/2; p++) begin
      model[2*p]   = rnd128();
      model[2*p+1] = rnd128();
      pair_valid   = 1'b1;
      pair_data    = {model[2*p], model[2*p+1]};
      gen_done     = (p == NK/2-1);
      step();
    end
    pair_valid = 1'b0;
    gen_done   = 1'b0;
    chk_b("refill_loaded", keys_loaded, 1'b1);
    chk_b("refill_err", err, 1'b0);
    replay = 1'b1;
    push_keys(NK);
    step();
    replay = 1'b0;
    stream_tail("refill", NK-1);

    // asynchronous reset mid-stream
    replay = 1'b1;
    push_keys(2);
    step();
    replay = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    #2;
    chk_b("arst_kv", key_valid, 1'b0);
    chk_b("arst_keyset", keyset, 1'b0);
    chk_b("arst_loaded", keys_loaded, 1'b0);
    chk_w("arst_key", key_out, '0);
    chk_i("arst_idx", key_idx, 4'd0);
    chk_b("arst_sb_empty", exp_q.size() == 0, 1'b1);
    step();
    rst_n = 1'b1;
    step();
    wait_scrub("arst");
    chk_b("arst_post_loaded", keys_loaded, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/kuznechik_key_store.md
Name: kuznechik_key_store

Overview:
- Sits between kuznechik_keygen and kuznechik_encrypt.
- Captures the round-key pairs the generator emits as 256-bit words on single-cycle ready pulses, and holds all NUM_KEYS 128-bit round keys.
- On request, replays the keys to the encrypt core as a contiguous K1..K10 stream with keyset/key_valid framing.
- Replaces the ad-hoc shift-register handoff; allows re-keying the cipher without regenerating keys.

Parameters:
- NUM_KEYS, 10, number of 128-bit round keys stored; must be even and >= 2.
- KEY_W, 128, width of one round key.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous flush: discard stored keys, restart fill.
- pair_valid  in  1  one-cycle pulse; pair_data valid this cycle.
- pair_data  in  2*KEY_W  [2*KEY_W-1:KEY_W] = K(2i+1), [KEY_W-1:0] = K(2i+2).
- gen_done  in  1  generator finished, single-cycle pulse.
- replay  in  1  pulse: stream stored keys to the cipher.
- key_out  out  KEY_W  current round key.
- key_valid  out  1  key_out valid this cycle.
- keyset  out  1  cipher must stay in key-load mode.
- keys_loaded  out  1  all NUM_KEYS keys present.
- key_idx  out  4  index 0..NUM_KEYS-1 of key_out.
- err  out  1  sticky protocol error.
- busy  out  1  scrub in progress; constant 0 without the macro.

Behaviour:
- Reset: all outputs 0; state FILL; write pointer 0; key memory 0.
- States: FILL, LOADED, REPLAY, plus SCRUB when the macro is defined.
- FILL:
  - pair_valid writes pair_data[hi] to slot wp and pair_data[lo] to slot wp+1; wp += 2.
  - After the NUM_KEYS/2-th pair: state LOADED; keys_loaded rises the cycle after that pair's pulse.
  - gen_done with wp != NUM_KEYS sets err; state stays FILL.
  - gen_done coincident with the last pair is legal.
- LOADED:
  - replay → REPLAY.
  - pair_valid drops the data and sets err; contents unchanged.
  - gen_done is ignored.
- REPLAY:
  - Starts the cycle after replay is sampled. keyset=1 and key_valid=1 for exactly NUM_KEYS consecutive cycles.
  - key_out = K(n+1) and key_idx = n, for n = 0..NUM_KEYS-1.
  - Cycle after the last key: keyset=0, key_valid=0, key_out=0, state LOADED.
  - replay during REPLAY is ignored; it does not restart the stream.
  - pair_valid drops the data and sets err.
- keyset is also 1 throughout FILL, so the cipher is held off until keys exist. It is 0 in LOADED.
- key_out is 0 whenever key_valid=0.
- replay in FILL is ignored and does not set err.
- clear has top priority in every state.
  - Next cycle: state FILL, wp=0, keys_loaded=0, key_valid=0, err=0.
  - A pair_valid coincident with clear is dropped.
  - A stream cut by clear is not resumed.
- rst_n mid-REPLAY aborts immediately; all outputs go to 0 asynchronously.
- Registered outputs only; no combinational path from any input to any output.

Optional Feature:
- Macro: KUZNECHIK_KEY_STORE_SCRUB_EN.
- Defined: clear (and leaving reset) enters SCRUB.
  - One slot zeroed per cycle for NUM_KEYS cycles; busy=1 and keyset=1 throughout; then FILL.
  - pair_valid during SCRUB is dropped and sets err.
- Undefined: clear only resets pointers and state; stale key contents persist until overwritten, but are never output before keys_loaded; busy tied 0.

Decomposition:
- Shared package kuznechik_pkg:
  - constants KEY_W=128 and NUM_ROUND_KEYS=10;
  - state encoding for FILL/LOADED/REPLAY/SCRUB;
  - GOST R 34.12-2015 test-vector round keys, for benches.
- One natural sub-module: kuznechik_key_ram. NUM_KEYS x KEY_W register file with one dual-slot (pair) write port and one read port.
- FSM, pointers and error logic stay in the top.

Test Plan:
- Fill with 5 GOST pairs, first = {8899aabbccddeeff0011223344556677, fedcba98765432100123456789abcdef}, gen_done with the 5th → keys_loaded=1 next cycle, err=0.
- replay pulse in LOADED → next 10 cycles key_valid=1, key_idx 0..9, key_out=K1..K10 (K1=8899…6677), then keyset=0, key_out=0.
- gen_done after only 3 pairs → err=1 and stays 1; keys_loaded=0.
- 6th pair_valid in LOADED, and replay re-pulsed mid-stream → err=1, stored K1..K10 unchanged, stream not restarted.
- clear asserted at stream cycle 4 → next cycle key_valid=0, keys_loaded=0, err=0; refill + replay yields new keys.
- With the macro defined, clear → busy=1 for 10 cycles, memory all 0; pair_valid in that window → err=1.
